axis_pixel_packer: RTL



---
 rtl/img_stream_pkg.sv | 26 ++
 rtl/axis_word_slot.sv | 46 ++++
 rtl/axis_pixel_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/img_stream_pkg.sv
// Shared widths, frame geometry and helpers for the 8-bit image stream stages.
package img_stream_pkg;

  localparam int PIX_W          = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = PIX_W * BYTES_PER_WORD;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  localparam int IMG_W = 512;
  localparam int IMG_H = 512;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef logic [WORD_W-1:0]         word_t;
  typedef logic [BYTES_PER_WORD-1:0] keep_t;
  typedef logic [LANE_W-1:0]         lane_t;

  // Byte-enable mask covering lanes 0..last_lane inclusive.
  function automatic keep_t keep_upto(lane_t last_lane);
    keep_t k;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      k[i] = (lane_t'(i) <= last_lane);
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_word_slot.sv
// Single-entry AXI-Stream output register: holds a payload until it handshakes,
// and accepts a new payload on the same edge the old one drains.
module axis_word_slot #(
  parameter int PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  output logic                 can_load,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // A load wins over the drain so a back-to-back word leaves no bubble.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d   = 1'b1;
      payload_d = load_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign can_load    = !valid_q || out_ready;
  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs 8-bit pixels four to a 32-bit AXI-Stream word, tlast on each frame's last word.
// Define PACKER_TKEEP_EN to add the m_axis_tkeep byte-enable output.
module axis_pixel_packer
  import img_stream_pkg::*;
#(
  parameter int         FRAME_PIXELS = IMG_W * IMG_H,
  parameter logic [7:0] PAD_VALUE    = 8'h00
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        s_data_valid,
  input  logic [7:0]  s_data,
  output logic        s_data_ready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
`ifdef PACKER_TKEEP_EN
  output logic [3:0]  m_axis_tkeep,
`endif
  input  logic        m_axis_tready,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count
);

  localparam int               CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
`ifdef PACKER_TKEEP_EN
  localparam int PAYLOAD_W = WORD_W + 1 + BYTES_PER_WORD;
`else
  localparam int PAYLOAD_W = WORD_W + 1;
`endif

  logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  lane_t                lane_q, lane_d;
  word_t                acc_q, acc_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 frame_done_q, frame_done_d;

  logic                 last_pix;
  logic                 completes;
  logic                 accept;
  logic                 load;
  logic                 slot_can_load;
  logic                 last_handshake;
  word_t                word;
  logic [PAYLOAD_W-1:0] load_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  assign last_pix     = (pix_cnt_q == LAST_PIX);
  assign completes    = (lane_q == lane_t'(BYTES_PER_WORD - 1)) || last_pix;
  // Only a completing pixel needs room in the slot; ready is held low in reset.
  assign s_data_ready = axi_reset_n && (!completes || slot_can_load);
  assign accept       = s_data_valid && s_data_ready;
  assign load         = accept && completes;

  // The completing pixel goes straight into the outgoing word, lanes above it pad.
  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane_t'(i) < lane_q) begin
        word[i*PIX_W +: PIX_W] = acc_q[i*PIX_W +: PIX_W];
      end else if (lane_t'(i) == lane_q) begin
        word[i*PIX_W +: PIX_W] = s_data;
      end else begin
        word[i*PIX_W +: PIX_W] = PAD_VALUE;
      end
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    if (accept) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
      if (completes) begin
        lane_d = '0;
      end else begin
        acc_d[lane_q*PIX_W +: PIX_W] = s_data;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  assign last_handshake = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    frame_done_d  = last_handshake;
    frame_count_d = frame_count_q;
    if (last_handshake) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      pix_cnt_q     <= '0;
      lane_q        <= '0;
      acc_q         <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      lane_q        <= lane_d;
      acc_q         <= acc_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
    end
  end

`ifdef PACKER_TKEEP_EN
  assign load_payload = {keep_upto(lane_q), last_pix, word};
  assign {m_axis_tkeep, m_axis_tlast, m_axis_tdata} = out_payload;
`else
  assign load_payload = {last_pix, word};
  assign {m_axis_tlast, m_axis_tdata} = out_payload;
`endif

  axis_word_slot #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_slot (
    .clk          (axi_clk),
    .rst_n        (axi_reset_n),
    .load         (load),
    .load_payload (load_payload),
    .can_load     (slot_can_load),
    .out_valid    (m_axis_tvalid),
    .out_payload  (out_payload),
    .out_ready    (m_axis_tready)
  );

  assign o_frame_done  = frame_done_q;
  assign o_frame_count = frame_count_q;

endmodule
